// File: rtl/sddac_upsampler_lin_pkg.sv
// Shared constants and FSM encoding for the sigma-delta DAC upsampler.
package sddac_upsampler_lin_pkg;

    localparam int SDDAC_SAMPLE_W    = 18;
    localparam int SDDAC_PROG_CYCLES = 8;

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } ups_state_e;

endpackage

// File: rtl/sddac_upsampler_chan.sv
// One channel of the linear interpolator: skid sample, segment target,
// slope and fixed-point accumulator, driven by strobes from the parent FSM.
module sddac_upsampler_chan
    import sddac_upsampler_lin_pkg::*;
#(
    parameter int OSR_LOG2 = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_capture,
    input  logic signed [SDDAC_SAMPLE_W-1:0] i_sample,
    input  logic                             i_hold,
    input  logic                             i_step,
    input  logic                             i_load,
    output logic signed [SDDAC_SAMPLE_W-1:0] o_sample
);

    localparam int W     = SDDAC_SAMPLE_W;
    localparam int ACC_W = W + OSR_LOG2 + 1;

    logic signed [W-1:0]     r_nxt;
    logic signed [W-1:0]     r_cur;
    logic signed [W:0]       r_dlt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [W-1:0]     r_out;

    logic signed [ACC_W-1:0] w_acc_new;
    logic signed [ACC_W-1:0] w_cur_acc;
    logic signed [W:0]       w_dlt_new;

    assign w_acc_new = r_acc + {{(ACC_W-W-1){r_dlt[W]}}, r_dlt};
    assign w_cur_acc = {r_cur[W-1], r_cur, {OSR_LOG2{1'b0}}};
    assign w_dlt_new = {r_nxt[W-1], r_nxt} - {r_cur[W-1], r_cur};

    // On the last step acc_new already equals cur << OSR_LOG2, so chaining
    // a new segment keeps the accumulator continuous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nxt <= '0;
            r_cur <= '0;
            r_dlt <= '0;
            r_acc <= '0;
            r_out <= '0;
        end else begin
            if (i_capture)
                r_nxt <= i_sample;
            if (i_step) begin
                r_acc <= w_acc_new;
                r_out <= w_acc_new[OSR_LOG2+W-1:OSR_LOG2];
            end else if (i_hold) begin
                r_out <= r_cur;
            end
            if (i_load) begin
                r_dlt <= w_dlt_new;
                r_cur <= r_nxt;
                r_acc <= i_step ? w_acc_new : w_cur_acc;
            end
        end
    end

    assign o_sample = r_out;

endmodule

// File: rtl/sddac_upsampler_lin.sv
// Stereo linear-interpolation upsampler: audio-rate samples in, one
// interpolated stereo sample every OUT_PERIOD clocks out to the DAC core.
module sddac_upsampler_lin
    import sddac_upsampler_lin_pkg::*;
#(
    parameter int OSR_LOG2   = 6,
    parameter int OUT_PERIOD = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic signed [SDDAC_SAMPLE_W-1:0] sample_in_l,
    input  logic signed [SDDAC_SAMPLE_W-1:0] sample_in_r,
    input  logic                             sample_in_valid,
    output logic                             sample_in_ready,
    output logic signed [SDDAC_SAMPLE_W-1:0] sample_out_l,
    output logic signed [SDDAC_SAMPLE_W-1:0] sample_out_r,
    output logic                             sample_out_rdy,
    output logic                             underrun
);

    if (OUT_PERIOD < SDDAC_PROG_CYCLES) begin : g_bad_period
        $error("OUT_PERIOD must cover the DAC program length");
    end

    localparam int               CNT_W   = $clog2(OUT_PERIOD);
    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(OUT_PERIOD - 1);

    logic [CNT_W-1:0]    r_tick_cnt;
    ups_state_e          r_state;
    logic [OSR_LOG2-1:0] r_phase;
    logic                r_nxt_vld;
    logic                r_rdy;
    logic                r_underrun;

    logic w_tick;
    logic w_accept;
    logic w_last;
    logic w_hold;
    logic w_step;
    logic w_load;

    assign w_tick   = (r_tick_cnt == TICK_AT);
    assign w_accept = sample_in_valid & ~r_nxt_vld;
    assign w_last   = &r_phase;
    assign w_hold   = w_tick & (r_state == S_HOLD);
    assign w_step   = w_tick & (r_state == S_RUN);
    assign w_load   = r_nxt_vld & (w_hold | (w_step & w_last));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_state    <= S_HOLD;
            r_phase    <= '0;
            r_nxt_vld  <= 1'b0;
            r_rdy      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_rdy      <= w_tick;
            r_underrun <= w_step & w_last & ~r_nxt_vld;

            // ready is low while full, so accept and load never coincide
            if (w_accept)
                r_nxt_vld <= 1'b1;
            else if (w_load)
                r_nxt_vld <= 1'b0;

            case (r_state)
                S_HOLD: begin
                    if (w_load) begin
                        r_state <= S_RUN;
                        r_phase <= '0;
                    end
                end
                S_RUN: begin
                    if (w_step) begin
                        r_phase <= r_phase + 1'b1;
                        if (w_last) begin
                            r_phase <= '0;
                            if (!r_nxt_vld)
                                r_state <= S_HOLD;
                        end
                    end
                end
                default: r_state <= S_HOLD;
            endcase
        end
    end

    assign sample_in_ready = ~r_nxt_vld;
    assign sample_out_rdy  = r_rdy;
    assign underrun        = r_underrun;

    sddac_upsampler_chan #(.OSR_LOG2(OSR_LOG2)) u_chan_l (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_accept),
        .i_sample  (sample_in_l),
        .i_hold    (w_hold),
        .i_step    (w_step),
        .i_load    (w_load),
        .o_sample  (sample_out_l)
    );

    sddac_upsampler_chan #(.OSR_LOG2(OSR_LOG2)) u_chan_r (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_accept),
        .i_sample  (sample_in_r),
        .i_hold    (w_hold),
        .i_step    (w_step),
        .i_load    (w_load),
        .o_sample  (sample_out_r)
    );

endmodule

// File: doc/sddac_upsampler_lin.md
Name: sddac_upsampler_lin

Overview:
- Stereo linear-interpolation upsampler feeding the sigma-delta DAC core.
- Accepts 18-bit signed stereo samples at the audio rate over a valid/ready handshake.
- Emits interpolated stereo samples with a one-cycle sample_out_rdy strobe every OUT_PERIOD clocks, so the modulator sees a smooth staircase at OSR = 2^OSR_LOG2 times the input rate.
- Sits between the synth mixer output and the DAC's sample_in_l/sample_in_r/sample_in_rdy inputs.

Parameters:
- OSR_LOG2, 6: log2 of interpolation steps per input sample (64x).
- OUT_PERIOD, 16: clocks between output strobes. Must be >= 8, the DAC program length; elaboration error otherwise.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- sample_in_l  in  18  signed left input sample
- sample_in_r  in  18  signed right input sample
- sample_in_valid  in  1  input sample present
- sample_in_ready  out  1  block can accept a sample this cycle
- sample_out_l  out  18  signed interpolated left sample
- sample_out_r  out  18  signed interpolated right sample
- sample_out_rdy  out  1  one-cycle strobe: sample_out_l/r valid
- underrun  out  1  one-cycle pulse: segment ended with no next sample queued

Behaviour:
- Reset values:
  - sample_out_l/r = 0, sample_out_rdy = 0, underrun = 0, sample_in_ready = 1.
  - tick counter = 0, state = S_HOLD.
  - cur, acc, dlt, phase, nxt_vld all 0.
- Tick generator:
  - Counter runs 0..OUT_PERIOD-1 from reset; tick is asserted when it reaches OUT_PERIOD-1, then it wraps to 0.
  - First tick occurs OUT_PERIOD clocks after reset release.
- Input skid:
  - One-entry register nxt_l/r plus nxt_vld; sample_in_ready = ~nxt_vld.
  - Transfer occurs when valid & ready; nxt is captured and nxt_vld set next cycle.
  - Accept and consume cannot coincide because ready is low while nxt_vld = 1.
- Per-channel datapath:
  - cur: 18-bit segment target.
  - dlt: 19-bit signed, equals nxt - cur.
  - acc: 18+OSR_LOG2+1 bits signed.
  - Output = acc[OSR_LOG2+17 : OSR_LOG2] (arithmetic floor).
  - No saturation is needed: acc stays between the segment endpoints. Full-scale step 0x1FFFF -> 0x20000 gives dlt = -262143, which fits in 19 bits.
- State S_HOLD, on tick:
  - Drive sample_out = cur and pulse sample_out_rdy.
  - If nxt_vld: dlt <= nxt - cur, cur <= nxt, acc <= cur << OSR_LOG2, phase <= 0, clear nxt_vld, go to S_RUN.
- State S_RUN, on tick:
  - acc_new = acc + dlt; acc <= acc_new.
  - sample_out <= acc_new >> OSR_LOG2; pulse sample_out_rdy; phase <= phase + 1.
  - When phase == 2^OSR_LOG2 - 1 (last step), acc_new equals cur << OSR_LOG2 exactly, so the output equals cur. In the same cycle:
    - If nxt_vld: load the next segment (same assignments as S_HOLD, with acc <= acc_new) and stay in S_RUN.
    - Else: pulse underrun and go to S_HOLD.
- Latency: a sample accepted before a segment boundary first affects the output at the first tick after that boundary. Steady-state pipeline delay is one input period.
- Outputs stay stable between strobes; sample_out_rdy is never high two consecutive cycles.
- Reset mid-segment: all state clears immediately (asynchronous reset); a pending nxt is discarded.

Decomposition:
- Shared header alongside the existing globals:
  - SDDAC_SAMPLE_W = 18.
  - SDDAC_PROG_CYCLES = 8.
  - State encodings S_HOLD and S_RUN.
- One sub-module, sddac_upsampler_chan: holds cur/nxt/dlt/acc and output for one channel, controlled by load/step strobes from the parent FSM. Instantiated twice (L/R).
- The parent owns the tick counter, phase, FSM, nxt_vld and handshake.

Test Plan:
1. Reset, no input, 3*16 clocks -> sample_out_rdy pulses at clocks 16, 32, 48; outputs 0; underrun never asserted.
2. Send L=64, R=-64 once -> next 64 strobes output L = 1, 2, ..., 64 and R = -1, -2, ..., -64; then one underrun pulse; outputs hold 64 / -64 on later strobes.
3. Stream L: 0x1FFFF then 0x20000, back-to-back with valid held high -> ready deasserts while the skid is full; after the ramp up, output descends monotonically to 0x20000 (-131072) with no wrap and no underrun between segments.
4. Continuous stream of 8 samples, valid always high -> no underrun; each boundary strobe output exactly equals the corresponding input sample.
5. Assert reset at phase 30 of a segment -> sample_out_l/r = 0, rdy = 0 and ready = 1 immediately; the first strobe comes 16 clocks after release.
6. OUT_PERIOD=8 build with the DAC core attached -> every strobe lands on the DAC's WAIT_IN state, and no sample is dropped over 1000 strobes.
